// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : multicycle_ctrl                                                   |
// | Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing,        |
// | datapath strobes, retired-instruction counter, halt on ECALL/illegal.      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_src,
   output logic             ir_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             i_or_d,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired,
   output logic             halted,
   output logic             illegal
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [6:0] c_OP_R     = 7'b0110011;
   localparam logic [6:0] c_OP_I     = 7'b0010011;
   localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
   localparam logic [6:0] c_OP_STORE = 7'b0100011;
   localparam logic [6:0] c_OP_BR    = 7'b1100011;
   localparam logic [6:0] c_OP_ECALL = 7'b1110011;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             illegal_q, illegal_d;
   logic             w_retire;

   // Opcode stays stable from DECODE to the next FETCH, so later states re-decode it.
   logic w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br, w_is_ecall;
   assign w_is_r     = (opcode == c_OP_R);
   assign w_is_i     = (opcode == c_OP_I);
   assign w_is_ld    = (opcode == c_OP_LOAD);
   assign w_is_st    = (opcode == c_OP_STORE);
   assign w_is_br    = (opcode == c_OP_BR) && (funct3[2:1] == 2'b00);
   assign w_is_ecall = (opcode == c_OP_ECALL);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         retired_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      illegal_d  = illegal_q;
      w_retire   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = 2'd0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      halted     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               alu_src_b = 2'd2;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            if (w_is_r || w_is_i || w_is_ld || w_is_st || w_is_br) begin
               state_d = S_EXEC;
            end else if (w_is_ecall) begin
               state_d = S_HALT;
            end else begin
               state_d   = S_HALT;
               illegal_d = 1'b1;
            end
         end
         S_EXEC: begin
            if (w_is_br) begin
               alu_op   = 2'd1;
               pc_src   = 1'b1;
               pc_write = funct3[0] ? ~zero : zero;
               w_retire = 1'b1;
               state_d  = S_FETCH;
            end else if (w_is_r) begin
               alu_op  = 2'd2;
               state_d = S_WB;
            end else if (w_is_i) begin
               alu_op    = 2'd2;
               alu_src_b = 2'd1;
               state_d   = S_WB;
            end else begin
               alu_src_b = 2'd1;
               state_d   = S_MEM;
            end
         end
         S_MEM: begin
            i_or_d    = 1'b1;
            mem_read  = w_is_ld;
            mem_write = w_is_st;
            if (mem_ready) begin
               if (w_is_ld) begin
                  state_d = S_WB;
               end else begin
                  w_retire = 1'b1;
                  state_d  = S_FETCH;
               end
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = w_is_ld;
            w_retire   = 1'b1;
            state_d    = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, w_retire};
   end

   assign state   = state_q;
   assign retired = retired_q;
   assign illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_multicycle_ctrl                                                |
// | Directed self-checking bench for multicycle_ctrl.                          |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [6:0]  opcode = 7'd0;
   logic [2:0]  funct3 = 3'd0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d;
   logic [1:0]  alu_src_b, alu_op;
   logic        reg_write, mem_to_reg, halted, illegal;
   logic [2:0]  state;
   logic [31:0] retired;

   int checks = 0;
   int failures = 0;

   multicycle_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct3(funct3),
      .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
      .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
      .i_or_d(i_or_d), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .state(state),
      .retired(retired), .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Strobe bundle: {pc_write,pc_src,ir_write,mem_read,mem_write,i_or_d,alu_src_b,alu_op,reg_write,mem_to_reg}
   logic [11:0] w_strobes;
   assign w_strobes = {pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d,
                       alu_src_b, alu_op, reg_write, mem_to_reg};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Inputs are changed right after a tick; comb outputs are sampled 1 ns later.
   task automatic settle();
      #1;
   endtask

   initial begin
      // Reset and start
      tick(); tick();
      rst = 1'b1;
      settle();
      check("rst_state", 32'(state), 32'd0);
      check("rst_strobes", 32'(w_strobes), 32'h000);
      check("rst_retired", retired, 32'd0);
      check("rst_flags", {30'd0, halted, illegal}, 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      settle();
      check("start_fetch", 32'(state), 32'd1);
      check("fetch_wait_strobes", 32'(w_strobes), 32'h100);
      tick();
      check("fetch_hold", 32'(state), 32'd1);

      // R-type
      opcode = 7'b0110011; funct3 = 3'd0; mem_ready = 1'b1;
      settle();
      check("fetch_ready_strobes", 32'(w_strobes), 32'hB20);
      tick();
      check("r_decode", 32'(state), 32'd2);
      check("r_decode_strobes", 32'(w_strobes), 32'h000);
      tick();
      check("r_exec", 32'(state), 32'd3);
      check("r_exec_strobes", 32'(w_strobes), 32'h008);
      tick();
      check("r_wb", 32'(state), 32'd5);
      check("r_wb_strobes", 32'(w_strobes), 32'h002);
      check("r_wb_retired", retired, 32'd0);
      tick();
      check("r_done", 32'(state), 32'd1);
      check("r_retired", retired, 32'd1);

      // LOAD with two wait cycles in MEM
      opcode = 7'b0000011;
      tick();
      tick();
      check("ld_exec_strobes", 32'(w_strobes), 32'h010);
      mem_ready = 1'b0;
      tick();
      check("ld_mem", 32'(state), 32'd4);
      check("ld_mem_strobes0", 32'(w_strobes), 32'h140);
      tick();
      check("ld_mem_hold", 32'(state), 32'd4);
      check("ld_mem_strobes1", 32'(w_strobes), 32'h140);
      mem_ready = 1'b1;
      settle();
      check("ld_mem_strobes2", 32'(w_strobes), 32'h140);
      tick();
      check("ld_wb", 32'(state), 32'd5);
      check("ld_wb_strobes", 32'(w_strobes), 32'h003);
      tick();
      check("ld_done", 32'(state), 32'd1);
      check("ld_retired", retired, 32'd2);

      // BEQ taken, BNE not taken, BNE taken
      opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
      tick(); tick();
      check("beq_exec_strobes", 32'(w_strobes), 32'hC04);
      tick();
      check("beq_done", 32'(state), 32'd1);
      check("beq_retired", retired, 32'd3);
      funct3 = 3'b001;
      tick(); tick();
      check("bne_z1_strobes", 32'(w_strobes), 32'h404);
      zero = 1'b0;
      settle();
      check("bne_z0_strobes", 32'(w_strobes), 32'hC04);
      tick();
      check("bne_done", 32'(state), 32'd1);
      check("bne_retired", retired, 32'd4);

      // Reset during STORE in MEM
      opcode = 7'b0100011; funct3 = 3'b010;
      tick(); tick();
      check("st_exec_strobes", 32'(w_strobes), 32'h010);
      mem_ready = 1'b0;
      tick();
      check("st_mem_strobes", 32'(w_strobes), 32'h0C0);
      check("st_mem_retired", retired, 32'd4);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      settle();
      check("st_rst_state", 32'(state), 32'd0);
      check("st_rst_strobes", 32'(w_strobes), 32'h000);
      check("st_rst_retired", retired, 32'd0);

      // Illegal opcode
      start = 1'b1; mem_ready = 1'b1; opcode = 7'h7F;
      tick();
      start = 1'b0;
      tick(); tick();
      check("ill_state", 32'(state), 32'd6);
      check("ill_flags", {30'd0, halted, illegal}, 32'd3);
      check("ill_strobes", 32'(w_strobes), 32'h000);
      start = 1'b1;
      tick(); tick();
      start = 1'b0;
      check("ill_start_ignored", 32'(state), 32'd6);

      // Branch with unsupported funct3 is illegal
      rst = 1'b0; tick(); rst = 1'b1;
      start = 1'b1; opcode = 7'b1100011; funct3 = 3'b100;
      tick();
      start = 1'b0;
      tick(); tick();
      check("blt_illegal", {29'd0, state}, 32'd6);
      check("blt_flags", {30'd0, halted, illegal}, 32'd3);

      // ECALL
      rst = 1'b0; tick(); rst = 1'b1;
      settle();
      check("ecall_rst_illegal", 32'(illegal), 32'd0);
      start = 1'b1; opcode = 7'b1110011; funct3 = 3'b000;
      tick();
      start = 1'b0;
      tick(); tick();
      check("ecall_state", 32'(state), 32'd6);
      check("ecall_flags", {30'd0, halted, illegal}, 32'd2);
      check("ecall_retired", retired, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
